// File: rtl/scan_mux.sv
// scan_mux: registered N-channel, W-bit bus multiplexer with manual, auto-scan
// and hold modes. Drives LED/display logic from several data sources.
//
// Ports:
//   clk     system clock, all state updates on the rising edge
//   rst     synchronous active-high reset (overrides mode/sel)
//   din     flattened channel inputs, channel i = din[i*WIDTH +: WIDTH]
//   sel     channel select, used in manual mode only
//   mode    00 manual, 01 auto-scan, 1x hold
//   ch_mask (only with SCAN_MASK_EN) bit i enables channel i in auto-scan
//   dout    registered selected data
//   cur_ch  index of the currently selected channel
//   ch_stb  one-cycle pulse on the cycle cur_ch takes a new value
//
// Optional feature macro: SCAN_MASK_EN adds ch_mask; auto-scan then skips
// disabled channels. Without it every channel is scanned in order.
module scan_mux #(
  parameter int WIDTH  = 8,
  parameter int CH_CNT = 4,
  parameter int SEL_W  = 2,
  parameter int DWELL  = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_CNT*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              mode,
`ifdef SCAN_MASK_EN
  input  logic [CH_CNT-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]        dout,
  output logic [SEL_W-1:0]        cur_ch,
  output logic                    ch_stb
);

  // One spare bit so DWELL-1 always fits, including DWELL=1.
  localparam int              CW       = $clog2(DWELL) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [SEL_W:0]  CH_LIM   = (SEL_W + 1)'(CH_CNT);

  logic [CH_CNT-1:0][WIDTH-1:0] ch;
  logic [CH_CNT-1:0]            en;
  logic [CW-1:0]                cnt, cnt_nxt;
  logic [SEL_W-1:0]             nxt, adv;

  assign ch = din;

`ifdef SCAN_MASK_EN
  assign en = ch_mask;
`else
  assign en = '1;
`endif

  // Next enabled channel strictly after cur_ch, searching upward with wrap.
  // Walking k downward lets the smallest offset win. cur_ch itself is never
  // a candidate, so a masked cur_ch is still left; no candidate -> hold.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_s;
    adv   = cur_ch;
    idx   = 0;
    idx_s = '0;
    for (int k = CH_CNT - 1; k >= 1; k--) begin
      idx = int'(cur_ch) + k;
      if (idx >= CH_CNT) idx = idx - CH_CNT;
      idx_s = SEL_W'(idx);
      if (en[idx_s]) adv = idx_s;
    end
  end

  always_comb begin
    nxt     = cur_ch;
    cnt_nxt = '0;
    case (mode)
      2'b00: begin
        // Out-of-range select is ignored.
        if ({1'b0, sel} < CH_LIM) nxt = sel;
      end
      2'b01: begin
        if (cnt == CNT_LAST) nxt = adv;
        else                 cnt_nxt = cnt + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ch <= '0;
      dout   <= '0;
      ch_stb <= 1'b0;
      cnt    <= '0;
    end else begin
      cur_ch <= nxt;
      cnt    <= cnt_nxt;
      ch_stb <= (nxt != cur_ch);
      // Hold freezes dout; other modes track live data on the next channel.
      if (!mode[1]) dout <= ch[nxt];
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;
  localparam int WIDTH  = 8;
  localparam int CH_CNT = 4;
  localparam int SEL_W  = 2;
  localparam int DWELL  = 3;
  localparam logic [31:0] DIN0 = 32'hD3C2B1A0;

  typedef struct {
    int ch;
    int d;
    int stb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [1:0]  sel;
  logic [1:0]  mode;
  logic [3:0]  tmask = 4'hF;
  logic [7:0]  dout;
  logic [1:0]  cur_ch;
  logic        ch_stb;

  always #5 clk = ~clk;

  scan_mux #(.WIDTH(WIDTH), .CH_CNT(CH_CNT), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .sel    (sel),
    .mode   (mode),
`ifdef SCAN_MASK_EN
    .ch_mask(tmask),
`endif
    .dout   (dout),
    .cur_ch (cur_ch),
    .ch_stb (ch_stb)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   drv_done = 0;

  // Reference state: channel index, output byte, elapsed dwell cycles.
  int m_ch = 0, m_dout = 0, m_stb = 0, m_cnt = 0;

  // Next enabled channel after c in scan order; stays on c if none.
  function automatic int next_en(int c, logic [3:0] mk);
    int r = c;
    for (int k = 1; k < CH_CNT; k++) begin
      int cand = (c + k) % CH_CNT;
      if (mk[cand]) return cand;
    end
    return r;
  endfunction

  task automatic cyc(input logic r, input logic [1:0] m, input logic [1:0] s,
                     input logic [31:0] d);
    int   n;
    exp_t e;
    rst = r; mode = m; sel = s; din = d;
    if (r) begin
      m_ch = 0; m_dout = 0; m_stb = 0; m_cnt = 0;
    end else begin
      n = m_ch;
      if (m == 2'b00) begin
        if (int'(s) < CH_CNT) n = int'(s);
        m_cnt = 0;
      end else if (m == 2'b01) begin
        if (m_cnt == DWELL - 1) begin
          m_cnt = 0;
          n = next_en(m_ch, tmask);
        end else m_cnt = m_cnt + 1;
      end else m_cnt = 0;
      m_stb = (n != m_ch) ? 1 : 0;
      if (m < 2) m_dout = int'(d[n*8 +: 8]);
      m_ch = n;
    end
    e.ch = m_ch; e.d = m_dout; e.stb = m_stb;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    cyc(1, 2'b00, 2'd0, DIN0);
    cyc(1, 2'b00, 2'd0, DIN0);
    repeat (3) cyc(0, 2'b00, 2'd2, DIN0);          // manual sel=2
    repeat (2) cyc(0, 2'b00, 2'd2, 32'hD35AB1A0);  // live data change on ch2
    repeat (10) cyc(0, 2'b01, 2'd0, DIN0);         // auto from 2 with wrap
    repeat (2) cyc(0, 2'b00, 2'd3, DIN0);          // park on ch3
    repeat (4) cyc(0, 2'b01, 2'd0, DIN0);
    cyc(0, 2'b10, 2'd0, DIN0);
    repeat (10) cyc(0, 2'b10, 2'd0, 32'hFFC2B1A0); // hold ignores din
    cyc(0, 2'b11, 2'd1, 32'hFFC2B1A0);
    repeat (2) cyc(0, 2'b00, 2'd3, 32'hFFC2B1A0);
    repeat (8) cyc(0, 2'b01, 2'd0, DIN0);
    cyc(1, 2'b01, 2'd0, DIN0);                     // reset mid-scan
    repeat (7) cyc(0, 2'b01, 2'd0, DIN0);
`ifdef SCAN_MASK_EN
    repeat (2) cyc(0, 2'b00, 2'd0, DIN0);
    tmask = 4'b1010;
    repeat (12) cyc(0, 2'b01, 2'd0, DIN0);
    tmask = 4'b0000;
    repeat (10) cyc(0, 2'b01, 2'd0, DIN0);
    tmask = 4'hF;
`endif
    for (int i = 0; i < 600; i++) begin
`ifdef SCAN_MASK_EN
      tmask = 4'($urandom);
`endif
      cyc(($urandom_range(0, 39) == 0), 2'($urandom), 2'($urandom), $urandom);
    end
    drv_done = 1;
  end

  // Monitor: one registered output per edge, matched in order.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (drv_done) break;
        n_cmp++; n_bad++;
        $display("FAIL qempty: no expected entry at %0t", $time);
      end else begin
        e = q.pop_front();
        n_cmp++;
        if (int'(cur_ch) !== e.ch || int'(dout) !== e.d || int'(ch_stb) !== e.stb) begin
          n_bad++;
          $display("FAIL out@%0t: got ch=%0d dout=%02h stb=%0b, want ch=%0d dout=%02h stb=%0d",
                   $time, cur_ch, dout, ch_stb, e.ch, e.d, e.stb);
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
